shift_unit_arbiter: RTL and testbench



---
 rtl/shift_unit_arbiter.sv | 117 +++++++++++
 tb/tb_shift_unit_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - two-requester round-robin arbiter in front of one 32-bit shifter
//
// Purpose: shares a single shift datapath (SLL/SRA/SRL/ROR) between two requesters.
//   A requester holds req/op/data/amt until its gnt. The granted operands are shifted
//   combinationally and registered into a one-deep result slot. The slot is drained
//   through a valid/ack handshake, and a new grant can refill it in the same cycle it
//   is acked.
//
// Ports:
//   clock, reset            - clock; synchronous active-high reset
//   req0/op0/data0/amt0     - requester 0 request, opcode, operand, shift amount
//   gnt0                    - combinational grant to requester 0 (operands captured this cycle)
//   req1/op1/data1/amt1     - requester 1, same as requester 0
//   gnt1                    - combinational grant to requester 1
//   res_valid/res_id/res_data - registered result, owning requester index, result data
//   res_ack                 - consumer accepts the result (ignored while res_valid=0)
module shift_unit_arbiter #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = 5,
  parameter int RESET_PRIO = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic [1:0]         op0,
  input  logic [WIDTH-1:0]   data0,
  input  logic [SHAMT_W-1:0] amt0,
  output logic               gnt0,
  input  logic               req1,
  input  logic [1:0]         op1,
  input  logic [WIDTH-1:0]   data1,
  input  logic [SHAMT_W-1:0] amt1,
  output logic               gnt1,
  output logic               res_valid,
  output logic               res_id,
  output logic [WIDTH-1:0]   res_data,
  input  logic               res_ack
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic               res_id_q, res_id_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;

  logic               slot_free;
  logic [1:0]         op_sel;
  logic [WIDTH-1:0]   data_sel;
  logic [SHAMT_W-1:0] amt_sel;
  logic [WIDTH-1:0]   shift_res;

  function automatic logic [WIDTH-1:0] do_shift(
    input logic [1:0]         op,
    input logic [WIDTH-1:0]   d,
    input logic [SHAMT_W-1:0] n
  );
    logic [SHAMT_W:0]   inv_n;
    logic [WIDTH-1:0]   r;
    // Left-shift amount for the rotate; n=0 gives WIDTH, which shifts everything out
    // and leaves the right-shift term (= d) as the result.
    inv_n = (SHAMT_W+1)'(WIDTH) - {1'b0, n};
    case (op)
      2'b00:   r = d << n;
      2'b01:   r = $signed(d) >>> n;
      2'b10:   r = d >> n;
      default: r = (d >> n) | (d << inv_n);
    endcase
    return r;
  endfunction

  // An ack in HOLD frees the slot in the same cycle, which gives back-to-back throughput.
  assign slot_free = (state_q == IDLE) || res_ack;

  // Requester 0 wins when alone or when it holds priority; requester 1 is the complement.
  assign gnt0 = !reset && slot_free && req0 && (!req1 || (prio_q == 1'b0));
  assign gnt1 = !reset && slot_free && req1 && (!req0 || (prio_q == 1'b1));

  assign op_sel    = gnt1 ? op1   : op0;
  assign data_sel  = gnt1 ? data1 : data0;
  assign amt_sel   = gnt1 ? amt1  : amt0;
  assign shift_res = do_shift(op_sel, data_sel, amt_sel);

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    res_id_d   = res_id_q;
    res_data_d = res_data_q;
    if (gnt0 || gnt1) begin
      state_d    = HOLD;
      res_id_d   = gnt1;
      res_data_d = shift_res;
      prio_d     = gnt0;  // hand priority to the requester that was not served
    end else if (state_q == HOLD && res_ack) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= 1'(RESET_PRIO);
      res_id_q   <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      res_id_q   <= res_id_d;
      res_data_q <= res_data_d;
    end
  end

  assign res_valid = (state_q == HOLD);
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb/tb_shift_unit_arbiter.sv - directed self-checking bench for shift_unit_arbiter
module tb_shift_unit_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, gnt0, gnt1;
  logic [1:0]  op0, op1;
  logic [31:0] data0, data1, res_data;
  logic [4:0]  amt0, amt1;
  logic        res_valid, res_id, res_ack;

  int tests_run = 0;
  int tests_failed = 0;

  shift_unit_arbiter #(.WIDTH(32), .SHAMT_W(5), .RESET_PRIO(0)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .op0(op0), .data0(data0), .amt0(amt0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .data1(data1), .amt1(amt1), .gnt1(gnt1),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ack(res_ack)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1; res_ack = 1'b0;
    req0 = 1'b1; op0 = 2'b00; data0 = '0; amt0 = '0;
    req1 = 1'b1; op1 = 2'b00; data1 = '0; amt1 = '0;

    // No grants while reset is asserted, even with both requests high
    #1;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    tick(); tick();
    req0 = 1'b0; req1 = 1'b0; reset = 1'b0;

    // Reset then idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      check("idle_valid", res_valid, 0);
      check("idle_gnt0", gnt0, 0);
      check("idle_gnt1", gnt1, 0);
      check("idle_data", res_data, 0);
      tick();
    end

    // Single SRA on requester 0
    req0 = 1'b1; op0 = 2'b01; data0 = 32'h8000_00F0; amt0 = 5'd4;
    #1;
    check("sra_gnt0", gnt0, 1);
    check("sra_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0;
    check("sra_valid", res_valid, 1);
    check("sra_id", res_id, 0);
    check("sra_data", res_data, 32'hF800_000F);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    check("sra_release", res_valid, 0);
    check("sra_keep", res_data, 32'hF800_000F);

    // All ops on requester 1 including amount boundaries 0 and 31
    vecs.push_back('{2'b00, 32'h8000_0001, 5'd1,  32'h0000_0002});
    vecs.push_back('{2'b10, 32'h8000_0001, 5'd1,  32'h4000_0000});
    vecs.push_back('{2'b01, 32'h8000_0001, 5'd1,  32'hC000_0000});
    vecs.push_back('{2'b11, 32'h8000_0001, 5'd1,  32'hC000_0000});
    vecs.push_back('{2'b00, 32'h8000_0001, 5'd0,  32'h8000_0001});
    vecs.push_back('{2'b01, 32'h8000_0001, 5'd0,  32'h8000_0001});
    vecs.push_back('{2'b10, 32'h8000_0001, 5'd0,  32'h8000_0001});
    vecs.push_back('{2'b11, 32'h8000_0001, 5'd0,  32'h8000_0001});
    vecs.push_back('{2'b00, 32'h8000_0001, 5'd31, 32'h8000_0000});
    vecs.push_back('{2'b01, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF});
    vecs.push_back('{2'b10, 32'h8000_0001, 5'd31, 32'h0000_0001});
    vecs.push_back('{2'b11, 32'h8000_0001, 5'd31, 32'h0000_0003});
    vecs.push_back('{2'b11, 32'h1234_5678, 5'd4,  32'h8123_4567});
    vecs.push_back('{2'b01, 32'h7000_0000, 5'd4,  32'h0700_0000});
    foreach (vecs[i]) begin
      req1 = 1'b1; op1 = vecs[i].op; data1 = vecs[i].data; amt1 = vecs[i].amt;
      #1;
      check($sformatf("op%0d_gnt1", i), gnt1, 1);
      tick();
      req1 = 1'b0;
      check($sformatf("op%0d_id", i), res_id, 1);
      check($sformatf("op%0d_data", i), res_data, vecs[i].exp);
      res_ack = 1'b1;
      tick();
      res_ack = 1'b0;
    end

    // Fresh reset so contention starts from the reset priority
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Contention: both requesting, ack tied high -> 0,1,0,1 with no bubble
    op0 = 2'b00; data0 = 32'h0000_0001; amt0 = 5'd1;
    op1 = 2'b10; data1 = 32'h0000_0100; amt1 = 5'd4;
    req0 = 1'b1; req1 = 1'b1; res_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("rr%0d_gnt0", i), gnt0, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_gnt1", i), gnt1, (i % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("rr%0d_valid", i), res_valid, 1);
      check($sformatf("rr%0d_id", i), res_id, i % 2);
      check($sformatf("rr%0d_data", i), res_data, (i % 2 == 0) ? 32'h2 : 32'h10);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    check("rr_release", res_valid, 0);

    // Backpressure: result held, requester 1 stalls until the ack
    req0 = 1'b1; res_ack = 1'b0;
    tick();
    req0 = 1'b0; req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_gnt1", i), gnt1, 0);
      check($sformatf("bp%0d_data", i), res_data, 32'h2);
      check($sformatf("bp%0d_valid", i), res_valid, 1);
      check($sformatf("bp%0d_id", i), res_id, 0);
      tick();
    end
    res_ack = 1'b1;
    #1;
    check("bp_ack_gnt1", gnt1, 1);
    tick();
    req1 = 1'b0;
    check("bp_new_valid", res_valid, 1);
    check("bp_new_id", res_id, 1);
    check("bp_new_data", res_data, 32'h10);

    // Reset mid-HOLD with prio pointing at requester 1
    req0 = 1'b1;
    #1;
    check("mh_pre_gnt0", gnt0, 1);
    tick();
    check("mh_hold", res_valid, 1);
    reset = 1'b1; req1 = 1'b1;
    #1;
    check("mh_rst_gnt0", gnt0, 0);
    check("mh_rst_gnt1", gnt1, 0);
    tick();
    check("mh_valid", res_valid, 0);
    check("mh_data", res_data, 0);
    reset = 1'b0;
    #1;
    check("mh_post_gnt0", gnt0, 1);
    check("mh_post_gnt1", gnt1, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    check("mh_post_valid", res_valid, 1);
    check("mh_post_id", res_id, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
